// File: rtl/tmng_sequencer.sv
// tmng_sequencer: drives one NAND-gate operation per command through the
// pin-level LOAD_A / READ_B / COMMIT / RELEASE handshake.
// Optional feature: define TMNG_SEQ_STATS_EN for the saturating op_count
// counter. Without it, op_count is tied to zero.
module tmng_sequencer #(
  parameter int unsigned HOLD = 3
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [6:0]  cmd_src_a,
  input  logic [6:0]  cmd_src_b,
  input  logic [6:0]  cmd_dst,
  output logic [7:0]  ui_out,
  output logic [7:0]  uio_out,
  input  logic        wb_i,
  output logic        rsp_valid,
  output logic        rsp_bit,
  output logic        busy,
  output logic [15:0] op_count
);

  typedef enum logic [2:0] {
    IDLE,
    LOAD_A,
    READ_B,
    COMMIT,
    RELEASE
  } state_t;

  localparam logic [3:0] HOLD_LAST = 4'(HOLD - 1);

  state_t     state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  logic [6:0] src_a_q, src_a_d;
  logic [6:0] src_b_q, src_b_d;
  logic [6:0] dst_q, dst_d;
  logic       rsp_bit_q, rsp_bit_d;
  logic [7:0] ui_q, ui_d;
  logic [7:0] uio_q, uio_d;
  logic       rsp_valid_q, rsp_valid_d;

  assign cmd_ready = (state_q == IDLE);
  assign busy      = (state_q != IDLE);
  assign ui_out    = ui_q;
  assign uio_out   = uio_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_bit   = rsp_bit_q;

  // Next-state, phase counter, operand latch and registered-output decode.
  // Pins are decoded from the next state so they change on the same edge
  // as the state register rather than one cycle later.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    src_a_d     = src_a_q;
    src_b_d     = src_b_q;
    dst_d       = dst_q;
    rsp_bit_d   = rsp_bit_q;
    ui_d        = '0;
    uio_d       = '0;
    rsp_valid_d = 1'b0;

    case (state_q)
      IDLE: begin
        if (cmd_valid && cmd_ready) begin
          state_d = LOAD_A;
          cnt_d   = HOLD_LAST;
          src_a_d = cmd_src_a;
          src_b_d = cmd_src_b;
          dst_d   = cmd_dst;
        end
      end
      LOAD_A: begin
        if (cnt_q == '0) begin
          state_d = READ_B;
          cnt_d   = HOLD_LAST;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      READ_B: begin
        if (cnt_q == '0) begin
          state_d   = COMMIT;
          rsp_bit_d = wb_i;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      COMMIT:  state_d = RELEASE;
      RELEASE: state_d = IDLE;
      default: state_d = IDLE;
    endcase

    case (state_d)
      LOAD_A: begin
        ui_d  = 8'h80;
        uio_d = {1'b0, src_a_d};
      end
      READ_B: begin
        ui_d  = {1'b0, src_b_d};
        uio_d = 8'h00;
      end
      COMMIT: begin
        ui_d  = 8'h80;
        uio_d = {1'b1, dst_d};
      end
      RELEASE: begin
        ui_d        = 8'h80;
        uio_d       = {1'b0, dst_d};
        rsp_valid_d = 1'b1;
      end
      default: begin
        ui_d  = 8'h00;
        uio_d = 8'h00;
      end
    endcase
  end

  // State, operand and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      src_a_q     <= '0;
      src_b_q     <= '0;
      dst_q       <= '0;
      rsp_bit_q   <= 1'b0;
      ui_q        <= '0;
      uio_q       <= '0;
      rsp_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      src_a_q     <= src_a_d;
      src_b_q     <= src_b_d;
      dst_q       <= dst_d;
      rsp_bit_q   <= rsp_bit_d;
      ui_q        <= ui_d;
      uio_q       <= uio_d;
      rsp_valid_q <= rsp_valid_d;
    end
  end

`ifdef TMNG_SEQ_STATS_EN
  logic [15:0] op_count_q;

  // Completed-operation counter, saturating at all ones.
  always_ff @(posedge clk) begin
    if (rst) begin
      op_count_q <= '0;
    end else if (rsp_valid_q && (op_count_q != '1)) begin
      op_count_q <= op_count_q + 16'd1;
    end
  end

  assign op_count = op_count_q;
`else
  assign op_count = '0;
`endif

endmodule

// File: tb/tb_tmng_sequencer.sv
// Self-checking bench for tmng_sequencer with a behavioural NAND-chip
// model (bit memory, operand-A latch, commit write-back).
module tb_tmng_sequencer;

  localparam int unsigned HOLD = 3;
  localparam int unsigned OPLEN = 2 * HOLD + 2;  // cycles 1..OPLEN are busy

  logic        clk;
  logic        rst;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [6:0]  cmd_src_a;
  logic [6:0]  cmd_src_b;
  logic [6:0]  cmd_dst;
  logic [7:0]  ui_out;
  logic [7:0]  uio_out;
  logic        wb_i;
  logic        rsp_valid;
  logic        rsp_bit;
  logic        busy;
  logic [15:0] op_count;

  int checks = 0;
  int failures = 0;

  tmng_sequencer #(.HOLD(HOLD)) dut (
    .clk       (clk),
    .rst       (rst),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_src_a (cmd_src_a),
    .cmd_src_b (cmd_src_b),
    .cmd_dst   (cmd_dst),
    .ui_out    (ui_out),
    .uio_out   (uio_out),
    .wb_i      (wb_i),
    .rsp_valid (rsp_valid),
    .rsp_bit   (rsp_bit),
    .busy      (busy),
    .op_count  (op_count)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Chip model: latches A while mode=1 and commit=0, tracks the NAND result
  // while mode=0, writes the result to addr2 when commit is high.
  logic [127:0] mem;
  logic [6:0]   a_reg;
  logic         res_reg;
  logic         load_en;
  logic [127:0] load_val;

  assign wb_i = ~(mem[a_reg] & mem[ui_out[6:0]]);

  always @(posedge clk) begin
    if (load_en) begin
      mem     <= load_val;
      a_reg   <= '0;
      res_reg <= 1'b0;
    end else begin
      if (uio_out[7]) mem[uio_out[6:0]] <= res_reg;
      if (ui_out[7] && !uio_out[7]) a_reg <= uio_out[6:0];
      if (!ui_out[7]) res_reg <= wb_i;
    end
  end

  // Reference: memory contents implied by the commands issued.
  logic [127:0] ref_mem;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic load_mem(input logic [127:0] v);
    load_val = v;
    load_en  = 1'b1;
    step();
    load_en  = 1'b0;
    ref_mem  = v;
  endtask

  // Called in cycle 1 of an accepted command; walks to the first IDLE cycle.
  task automatic run_trace(input logic [6:0] a, input logic [6:0] b, input logic [6:0] d);
    logic       exp_bit;
    logic [7:0] e_ui, e_uio;
    exp_bit    = ~(ref_mem[a] & ref_mem[b]);
    ref_mem[d] = exp_bit;
    for (int k = 1; k <= int'(OPLEN) + 1; k++) begin
      if (k <= int'(HOLD)) begin
        e_ui = 8'h80; e_uio = {1'b0, a};
      end else if (k <= 2 * int'(HOLD)) begin
        e_ui = {1'b0, b}; e_uio = 8'h00;
      end else if (k == 2 * int'(HOLD) + 1) begin
        e_ui = 8'h80; e_uio = {1'b1, d};
      end else if (k == 2 * int'(HOLD) + 2) begin
        e_ui = 8'h80; e_uio = {1'b0, d};
      end else begin
        e_ui = 8'h00; e_uio = 8'h00;
      end
      chk($sformatf("ui_out c%0d", k), ui_out, e_ui);
      chk($sformatf("uio_out c%0d", k), uio_out, e_uio);
      chk($sformatf("rsp_valid c%0d", k), rsp_valid, k == int'(OPLEN));
      chk($sformatf("busy c%0d", k), busy, k <= int'(OPLEN));
      chk($sformatf("cmd_ready c%0d", k), cmd_ready, k == int'(OPLEN) + 1);
      if (k == int'(OPLEN)) chk("rsp_bit", rsp_bit, exp_bit);
      if (k <= int'(OPLEN)) step();
    end
    chk("chip_mem_dst", mem[d], exp_bit);
    chk("chip_mem_all", mem, ref_mem);
  endtask

  task automatic wait_ready();
    int w = 0;
    while (!cmd_ready && w < 50) begin
      step();
      w++;
    end
    chk("ready_wait", cmd_ready, 1'b1);
  endtask

  // Accept one command, then scramble the operand inputs while it runs.
  task automatic do_cmd(input logic [6:0] a, input logic [6:0] b, input logic [6:0] d);
    wait_ready();
    cmd_src_a = a; cmd_src_b = b; cmd_dst = d;
    cmd_valid = 1'b1;
    step();
    cmd_valid = 1'b0;
    cmd_src_a = 7'($urandom); cmd_src_b = 7'($urandom); cmd_dst = 7'($urandom);
    run_trace(a, b, d);
  endtask

  task automatic start_to_cycle(input logic [6:0] a, input logic [6:0] b,
                                input logic [6:0] d, input int cyc);
    wait_ready();
    cmd_src_a = a; cmd_src_b = b; cmd_dst = d;
    cmd_valid = 1'b1;
    step();
    cmd_valid = 1'b0;
    for (int i = 1; i < cyc; i++) step();
  endtask

  task automatic check_idle_after_reset(input string tag);
    chk({tag, " ui_out"}, ui_out, 8'h00);
    chk({tag, " uio_out"}, uio_out, 8'h00);
    chk({tag, " rsp_valid"}, rsp_valid, 1'b0);
    chk({tag, " rsp_bit"}, rsp_bit, 1'b0);
    chk({tag, " busy"}, busy, 1'b0);
    chk({tag, " cmd_ready"}, cmd_ready, 1'b1);
    chk({tag, " op_count"}, op_count, 16'h0000);
  endtask

  initial begin
    logic [127:0] v;
    int acc, rsp_cnt, commit_hi, prev_commit, cyc;
    int commit_at[$];
    int exp_ops;
    logic [6:0] ra, rb, rd;

    rst = 1'b1; cmd_valid = 1'b0;
    cmd_src_a = '0; cmd_src_b = '0; cmd_dst = '0;
    load_en = 1'b0; load_val = '0;
    v = '0; v[5] = 1'b1; v[9] = 1'b1;
    load_mem(v);
    step();
    check_idle_after_reset("reset");
    rst = 1'b0;

    // Directed operation with both operands set, then with B cleared.
    do_cmd(7'd5, 7'd9, 7'd12);
    chk("nand_11_result", mem[12], 1'b0);
    v = ref_mem; v[9] = 1'b0;
    load_mem(v);
    do_cmd(7'd5, 7'd9, 7'd12);
    chk("nand_10_result", mem[12], 1'b1);

    // Aliased operands.
    do_cmd(7'd7, 7'd7, 7'd7);
    do_cmd(7'd7, 7'd7, 7'd7);

    // Randomized commands over random memory contents.
    load_mem({$urandom, $urandom, $urandom, $urandom});
    for (int n = 0; n < 20; n++) begin
      do_cmd(7'($urandom), 7'($urandom_range(0, 3)), 7'($urandom));
    end

    // Back-to-back: cmd_valid held until three commands have been accepted.
    wait_ready();
    ra = 7'($urandom); rb = 7'($urandom); rd = 7'($urandom);
    cmd_src_a = ra; cmd_src_b = rb; cmd_dst = rd;
    cmd_valid = 1'b1;
    acc = 0; rsp_cnt = 0; commit_hi = 0; prev_commit = 0;
    for (cyc = 0; cyc < 3 * (int'(OPLEN) + 1) + 4; cyc++) begin
      if (cmd_valid && cmd_ready) acc++;
      step();
      if (acc == 3) cmd_valid = 1'b0;
      if (rsp_valid) rsp_cnt++;
      if (uio_out[7]) commit_hi++;
      if (uio_out[7] && !prev_commit) commit_at.push_back(cyc);
      prev_commit = uio_out[7];
    end
    for (int i = 0; i < 3; i++) ref_mem[rd] = ~(ref_mem[ra] & ref_mem[rb]);
    chk("b2b accepted", acc, 3);
    chk("b2b rsp_valid count", rsp_cnt, 3);
    chk("b2b commit high cycles", commit_hi, 3);
    chk("b2b commit rises", commit_at.size(), 3);
    // Rise-to-rise distance of 2*HOLD+3 edges spans 2*HOLD+4 cycles inclusive.
    if (commit_at.size() == 3) begin
      chk("b2b spacing 1", commit_at[1] - commit_at[0] + 1, 2 * HOLD + 4);
      chk("b2b spacing 2", commit_at[2] - commit_at[1] + 1, 2 * HOLD + 4);
    end
    chk("b2b chip_mem", mem, ref_mem);

    // Reset in cycle 4 of an operation: aborted, memory untouched.
    start_to_cycle(7'd5, 7'd9, 7'd12, 4);
    chk("abort pre busy", busy, 1'b1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    check_idle_after_reset("abort_rd");
    rsp_cnt = 0;
    for (int i = 0; i < int'(OPLEN) + 2; i++) begin
      step();
      if (rsp_valid) rsp_cnt++;
    end
    chk("abort_rd no rsp", rsp_cnt, 0);
    chk("abort_rd chip_mem", mem, ref_mem);

    // Reset while commit is high: commit drops on the next cycle.
    ra = 7'd20; rb = 7'd21; rd = 7'd22;
    start_to_cycle(ra, rb, rd, 2 * HOLD + 1);
    chk("abort_cm commit high", uio_out, {1'b1, rd});
    rst = 1'b1;
    step();
    rst = 1'b0;
    ref_mem[rd] = ~(ref_mem[ra] & ref_mem[rb]);  // chip saw the commit edge
    check_idle_after_reset("abort_cm");
    rsp_cnt = 0;
    for (int i = 0; i < 4; i++) begin
      step();
      if (rsp_valid) rsp_cnt++;
    end
    chk("abort_cm no rsp", rsp_cnt, 0);
    chk("abort_cm chip_mem", mem, ref_mem);

    // cmd_valid during reset is ignored; accepted on the first free cycle.
    cmd_src_a = 7'd1; cmd_src_b = 7'd2; cmd_dst = 7'd3;
    cmd_valid = 1'b1;
    rst = 1'b1;
    step();
    step();
    check_idle_after_reset("rst_hold");
    rst = 1'b0;
    step();
    cmd_valid = 1'b0;
    run_trace(7'd1, 7'd2, 7'd3);

    // Statistics: five completions after a reset.
    rst = 1'b1;
    step();
    rst = 1'b0;
    for (int n = 0; n < 5; n++) begin
      do_cmd(7'($urandom), 7'($urandom), 7'($urandom));
    end
    step();
`ifdef TMNG_SEQ_STATS_EN
    exp_ops = 5;
`else
    exp_ops = 0;
`endif
    chk("op_count", op_count, 16'(exp_ops));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
